// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register with a single-outstanding-request imem port.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_fetch_stage #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(0)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pc_write_en,
    input  logic                ifid_write_en,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_target,
    input  logic                jump,
    input  logic [ADDR_W-1:0]   jump_target,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                imem_valid,
    output logic [ADDR_W-1:0]   ifid_pc,
    output logic [ADDR_W-1:0]   ifid_pc4,
    output logic [31:0]         ifid_instr,
    output logic                ifid_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_stall,
    output logic [15:0]         perf_flush
`endif
);

    localparam int unsigned INSTR_W = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [ADDR_W-1:0]    pc, pc_n;
    logic [INSTR_W-1:0]   hold_buf, hold_buf_n;
    logic [ADDR_W-1:0]    ifid_pc_n, ifid_pc4_n;
    logic [INSTR_W-1:0]   ifid_instr_n;
    logic                 ifid_valid_n;
    logic                 load;

    logic                 stall;
    logic                 redirect;
    logic [ADDR_W-1:0]    target;
    logic [ADDR_W-1:0]    pc_plus4;

    assign stall    = ~(pc_write_en & ifid_write_en);
    assign redirect = branch_taken | jump;
    assign target   = branch_taken ? branch_target : jump_target;
    assign pc_plus4 = pc + ADDR_W'(4);

    // Request is a decode of the state register, forced low while reset is held.
    assign imem_req  = (state == FETCH) & ~rst;
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            hold_buf   <= INSTR_W'(0);
            ifid_pc    <= ADDR_W'(0);
            ifid_pc4   <= ADDR_W'(0);
            ifid_instr <= INSTR_W'(0);
            ifid_valid <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            hold_buf   <= hold_buf_n;
            ifid_pc    <= ifid_pc_n;
            ifid_pc4   <= ifid_pc4_n;
            ifid_instr <= ifid_instr_n;
            ifid_valid <= ifid_valid_n;
        end
    end

    // Next-state and IF/ID update; redirect outranks stall in every state.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        hold_buf_n   = hold_buf;
        ifid_pc_n    = ifid_pc;
        ifid_pc4_n   = ifid_pc4;
        ifid_instr_n = ifid_instr;
        ifid_valid_n = ifid_valid;
        load         = 1'b0;

        case (state)
            FETCH: begin
                if (redirect) begin
                    pc_n         = target;
                    ifid_instr_n = INSTR_W'(0);
                    ifid_valid_n = 1'b0;
                    // A request still in flight must complete before the address may move.
                    if (!imem_valid) begin
                        state_n = DRAIN;
                    end
                end else if (imem_valid) begin
                    if (!stall) begin
                        ifid_pc_n    = pc;
                        ifid_pc4_n   = pc_plus4;
                        ifid_instr_n = imem_rdata;
                        ifid_valid_n = 1'b1;
                        pc_n         = pc_plus4;
                        load         = 1'b1;
                    end else begin
                        hold_buf_n = imem_rdata;
                        state_n    = HOLD;
                    end
                end else if (ifid_write_en) begin
                    ifid_instr_n = INSTR_W'(0);
                    ifid_valid_n = 1'b0;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pc_n         = target;
                    ifid_instr_n = INSTR_W'(0);
                    ifid_valid_n = 1'b0;
                end
                if (imem_valid) begin
                    state_n = FETCH;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_n         = target;
                    hold_buf_n   = INSTR_W'(0);
                    ifid_instr_n = INSTR_W'(0);
                    ifid_valid_n = 1'b0;
                    state_n      = FETCH;
                end else if (!stall) begin
                    ifid_pc_n    = pc;
                    ifid_pc4_n   = pc_plus4;
                    ifid_instr_n = hold_buf;
                    ifid_valid_n = 1'b1;
                    pc_n         = pc_plus4;
                    load         = 1'b1;
                    state_n      = FETCH;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

`ifdef IF_PERF_CNT_EN
    // Free-running event counters; wrap naturally on overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
            perf_flush   <= 16'd0;
        end else begin
            if (load) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (stall) begin
                perf_stall <= perf_stall + 32'd1;
            end
            if (redirect) begin
                perf_flush <= perf_flush + 16'd1;
            end
        end
    end
`endif

endmodule
